wb_writer: RTL and testbench
============================

# wb_writer

Register write-back driver on the writer side of the 15-entry register file's single write port (Dest_wb / Result_WB / writeBackEn). It merges two producers: the single-cycle ALU pipe, which is never stalled by this block, and a multi-cycle external unit (load/multiply), which is buffered in a small FIFO. It presents one registered write per cycle to the register file, which samples on the falling edge. It also exports a pending-destination mask so hazard logic can stall readers of registers with writes still in flight.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 4, register index width
- FIFO_DEPTH, 4, external-write buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before a stall is requested

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU write request this cycle
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ext_valid  in  1  external unit write offer
- ext_ready  out  1  FIFO can accept; transfer when ext_valid && ext_ready
- ext_dest  in  ADDR_W  external destination register
- ext_data  in  DATA_W  external result
- wb_en  out  1  write enable to register file (writeBackEn)
- wb_dest  out  ADDR_W  destination (Dest_wb)
- wb_data  out  DATA_W  data (Result_WB)
- alu_stall  out  1  registered request: upstream must hold alu_valid low
- pending_mask  out  16  bit d set while a write to reg d is buffered or on wb outputs
- pc_write_err  out  1  sticky: a write to reg 15 was dropped

## Operation
- Output register (wb_en/wb_dest/wb_data) loads every rising edge. Selection:
  1. alu_valid with alu_dest != 15: load ALU write.
  2. Otherwise, FIFO non-empty: pop head and load it.
  3. Otherwise: wb_en <= 0; wb_dest and wb_data hold their values.
- ALU is never dropped. If alu_valid is high while alu_stall is high, the ALU still wins. Upstream must prevent this; the condition is legal but not a fault.
- Push: ext_valid && ext_ready writes the tail. ext_ready = !rst && count < FIFO_DEPTH, computed from the registered count only. A full FIFO with a same-cycle pop still shows ext_ready=0.
- Simultaneous push and pop in one cycle: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Dest 15 (PC), from either source: the write is consumed (ext handshake completes, or ALU cycle passes) but never reaches the wb outputs or the FIFO, and pc_write_err <= 1. An ALU write to 15 leaves the cycle free for a FIFO pop.
- Starvation counter: cleared when the FIFO is empty or a pop occurs. Otherwise it increments while the head is blocked by the ALU, saturating at STARVE_LIMIT. alu_stall <= (counter == STARVE_LIMIT). It clears the cycle after the pop.
- pending_mask is combinational: OR of one-hot(dest) over valid FIFO entries, plus one-hot(wb_dest) when wb_en=1. Bit 15 is always 0.
- Write ordering between sources is not resolved here. The hazard unit must use pending_mask.

## Timing
- Reset values: wb_en=0, wb_dest=0, wb_data=0, alu_stall=0, pc_write_err=0, FIFO empty, counter 0, pending_mask=0, ext_ready=0 while rst is high.
- Reset mid-operation: buffered writes are discarded and none reach wb_en.
- ALU latency: request at edge N appears on wb outputs after edge N, so it is written at the falling edge of cycle N. Each request is one cycle.
- Ext latency with an idle path: push at edge N, pop at edge N+1, visible after N+1 (2 edges).
- Throughput: one write per cycle total. The FIFO drains at most one entry per cycle.

## Configuration
- WB_BYPASS_EN defined: when the FIFO is empty and no ALU write is selected, a handshaking ext write (dest != 15) loads the output register directly at the same edge, skipping the FIFO. Latency drops to 1 edge.
- Undefined: all ext writes pass through the FIFO, with 2-edge minimum latency.

## Test plan
- Reset, then alu_valid with dest 3, data 0xDEADBEEF for 1 cycle -> next cycle wb_en=1, wb_dest=3, wb_data=0xDEADBEEF; following cycle wb_en=0.
- Push ext dest 5 = 0x11, 6 = 0x22, 7 = 0x33, 8 = 0x44 while alu_valid is held high -> ext_ready=0 after the 4th push; pending_mask bits 5–8 set; drain order 5, 6, 7, 8 once the ALU goes idle.
- FIFO holding one entry with alu_valid continuously high -> alu_stall=1 after STARVE_LIMIT=8 blocked cycles; drop alu_valid -> head written next edge, alu_stall=0 one cycle later.
- Full FIFO, same-cycle pop and ext_valid -> no push that cycle (ext_ready=0); push accepted the next cycle; count stays ≤ 4.
- ALU write dest 15 plus a pending FIFO entry dest 2 -> FIFO entry written, wb_dest=2; pc_write_err=1 and stays set until rst.
- Assert rst with 3 entries buffered -> wb_en stays 0 and pending_mask=0 after release. With WB_BYPASS_EN, an ext write on an idle path appears on wb outputs one edge after the push.

Source files
------------

// File: rtl/wb_writer.sv
// Register-file write-back driver: merges an unstallable ALU pipe with a FIFO-buffered
// external unit onto one registered write port. Optional macro WB_BYPASS_EN lets ext writes skip an empty FIFO.
module wb_writer #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [ADDR_W-1:0] ext_dest,
  input  logic [DATA_W-1:0] ext_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              alu_stall,
  output logic [15:0]       pending_mask,
  output logic              pc_write_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

  logic [ADDR_W-1:0]     fifo_dest [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;

  logic ext_fire, ext_is_pc, alu_is_pc, alu_sel, fifo_empty, pop, push, bypass;

  // Handshake: a transfer happens on a rising edge where ext_valid && ext_ready;
  // ext_ready depends only on the registered count, never on a same-cycle pop.
  assign ext_ready  = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign ext_fire   = ext_valid && ext_ready;
  assign ext_is_pc  = (ext_dest == PC_REG);
  assign alu_is_pc  = (alu_dest == PC_REG);
  assign alu_sel    = alu_valid && !alu_is_pc;
  assign fifo_empty = (count == '0);
  assign pop        = !alu_sel && !fifo_empty;
`ifdef WB_BYPASS_EN
  assign bypass     = ext_fire && !ext_is_pc && fifo_empty && !alu_sel;
`else
  assign bypass     = 1'b0;
`endif
  assign push       = ext_fire && !ext_is_pc && !bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= ext_dest;
      fifo_data[wr_ptr] <= ext_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_W'(1);
        fifo_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fifo_vld[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ALU always wins the port; the FIFO head only drains on cycles the ALU leaves free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
    end else if (alu_sel) begin
      wb_en   <= 1'b1;
      wb_dest <= alu_dest;
      wb_data <= alu_data;
    end else if (pop) begin
      wb_en   <= 1'b1;
      wb_dest <= fifo_dest[rd_ptr];
      wb_data <= fifo_data[rd_ptr];
    end else if (bypass) begin
      wb_en   <= 1'b1;
      wb_dest <= ext_dest;
      wb_data <= ext_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  // A non-empty FIFO without a pop means the ALU took the port this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt   <= '0;
      alu_stall    <= 1'b0;
      pc_write_err <= 1'b0;
    end else begin
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != STV_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + STV_W'(1);
      alu_stall    <= (starve_cnt == STV_W'(STARVE_LIMIT));
      pc_write_err <= pc_write_err || (alu_valid && alu_is_pc) || (ext_fire && ext_is_pc);
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (fifo_vld[i]) pending_mask = pending_mask | (16'(1) << fifo_dest[i]);
    if (wb_en) pending_mask = pending_mask | (16'(1) << wb_dest);
    pending_mask[15] = 1'b0;
  end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: reset, ALU path, FIFO fill/drain, starvation stall,
// full-with-pop, PC-write drop, mid-operation reset, and the WB_BYPASS_EN latency.
module tb_wb_writer;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ext_valid;
  logic        ext_ready;
  logic [3:0]  ext_dest;
  logic [31:0] ext_data;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        alu_stall;
  logic [15:0] pending_mask;
  logic        pc_write_err;

  int checks = 0;
  int passes = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;

  wb_writer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_dest(ext_dest), .ext_data(ext_data),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .alu_stall(alu_stall), .pending_mask(pending_mask), .pc_write_err(pc_write_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    ext_valid = 1'b0; ext_dest = '0; ext_data = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL rst_wb_en: got %0b exp 0", wb_en); else passes++;
    checks++; if (wb_dest !== 4'd0) $display("FAIL rst_wb_dest: got %0d exp 0", wb_dest); else passes++;
    checks++; if (wb_data !== 32'd0) $display("FAIL rst_wb_data: got %h exp 0", wb_data); else passes++;
    checks++; if (alu_stall !== 1'b0) $display("FAIL rst_stall: got %0b exp 0", alu_stall); else passes++;
    checks++; if (pc_write_err !== 1'b0) $display("FAIL rst_pc_err: got %0b exp 0", pc_write_err); else passes++;
    checks++; if (pending_mask !== 16'h0) $display("FAIL rst_mask: got %h exp 0", pending_mask); else passes++;
    checks++; if (ext_ready !== 1'b0) $display("FAIL rst_ready: got %0b exp 0", ext_ready); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (ext_ready !== 1'b1) $display("FAIL post_rst_ready: got %0b exp 1", ext_ready); else passes++;
  endtask

  task automatic test_alu;
    alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    checks++; if (wb_en !== 1'b1) $display("FAIL alu_en: got %0b exp 1", wb_en); else passes++;
    checks++; if (wb_dest !== 4'd3) $display("FAIL alu_dest: got %0d exp 3", wb_dest); else passes++;
    checks++; if (wb_data !== 32'hDEADBEEF) $display("FAIL alu_data: got %h exp deadbeef", wb_data); else passes++;
    checks++; if (pending_mask !== 16'h0008) $display("FAIL alu_mask: got %h exp 0008", pending_mask); else passes++;
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL alu_en_off: got %0b exp 0", wb_en); else passes++;
    checks++; if (wb_dest !== 4'd3) $display("FAIL alu_dest_hold: got %0d exp 3", wb_dest); else passes++;
  endtask

  task automatic test_ext_latency;
    ext_valid = 1'b1; ext_dest = 4'd4; ext_data = 32'h44;
    tick();
    ext_valid = 1'b0;
`ifdef WB_BYPASS_EN
    checks++; if (wb_en !== 1'b1) $display("FAIL byp_en: got %0b exp 1", wb_en); else passes++;
    checks++; if (wb_dest !== 4'd4) $display("FAIL byp_dest: got %0d exp 4", wb_dest); else passes++;
    checks++; if (wb_data !== 32'h44) $display("FAIL byp_data: got %h exp 44", wb_data); else passes++;
`else
    checks++; if (wb_en !== 1'b0) $display("FAIL ext_lat_en1: got %0b exp 0", wb_en); else passes++;
    checks++; if (pending_mask !== 16'h0010) $display("FAIL ext_lat_mask: got %h exp 0010", pending_mask); else passes++;
    tick();
    checks++; if (wb_en !== 1'b1) $display("FAIL ext_lat_en2: got %0b exp 1", wb_en); else passes++;
    checks++; if (wb_dest !== 4'd4) $display("FAIL ext_lat_dest: got %0d exp 4", wb_dest); else passes++;
    checks++; if (wb_data !== 32'h44) $display("FAIL ext_lat_data: got %h exp 44", wb_data); else passes++;
`endif
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL ext_lat_off: got %0b exp 0", wb_en); else passes++;
  endtask

  task automatic test_fill_drain;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      ext_valid = 1'b1; ext_dest = 4'(5 + i); ext_data = 32'(17 * (i + 1));
      checks++; if (ext_ready !== 1'b1) $display("FAIL fill_ready%0d: got %0b exp 1", i, ext_ready); else passes++;
      exp_q.push_back({ext_dest, ext_data});
      tick();
    end
    ext_valid = 1'b0;
    checks++; if (ext_ready !== 1'b0) $display("FAIL fill_full: got %0b exp 0", ext_ready); else passes++;
    checks++; if (pending_mask !== 16'h01E2) $display("FAIL fill_mask: got %h exp 01e2", pending_mask); else passes++;
    checks++; if (wb_dest !== 4'd1) $display("FAIL fill_alu_wins: got %0d exp 1", wb_dest); else passes++;
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = exp_q.pop_front();
      checks++; if (wb_en !== 1'b1 || {wb_dest, wb_data} !== exp_w)
        $display("FAIL drain%0d: got en=%0b %0d/%h exp 1 %0d/%h", i, wb_en, wb_dest, wb_data, exp_w[35:32], exp_w[31:0]);
      else passes++;
    end
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL drain_idle: got %0b exp 0", wb_en); else passes++;
    checks++; if (pending_mask !== 16'h0) $display("FAIL drain_mask: got %h exp 0", pending_mask); else passes++;
  endtask

  task automatic test_starve;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'h1;
    ext_valid = 1'b1; ext_dest = 4'd9; ext_data = 32'h99;
    tick();
    ext_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (alu_stall !== 1'b0) $display("FAIL starve_early: got %0b exp 0", alu_stall); else passes++;
    tick();
    tick();
    checks++; if (alu_stall !== 1'b1) $display("FAIL starve_stall: got %0b exp 1", alu_stall); else passes++;
    alu_valid = 1'b0;
    tick();
    checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd9 || wb_data !== 32'h99)
      $display("FAIL starve_pop: got en=%0b %0d/%h exp 1 9/99", wb_en, wb_dest, wb_data);
    else passes++;
    checks++; if (alu_stall !== 1'b1) $display("FAIL starve_hold: got %0b exp 1", alu_stall); else passes++;
    tick();
    checks++; if (alu_stall !== 1'b0) $display("FAIL starve_clear: got %0b exp 0", alu_stall); else passes++;
  endtask

  task automatic test_full_pop;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      ext_valid = 1'b1; ext_dest = 4'(10 + i); ext_data = 32'(10 + i);
      tick();
    end
    checks++; if (ext_ready !== 1'b0) $display("FAIL fp_full: got %0b exp 0", ext_ready); else passes++;
    alu_valid = 1'b0;
    ext_valid = 1'b1; ext_dest = 4'd14; ext_data = 32'hEE;
    tick();
    checks++; if (wb_dest !== 4'd10 || wb_data !== 32'hA) $display("FAIL fp_pop0: got %0d/%h exp 10/a", wb_dest, wb_data); else passes++;
    checks++; if (ext_ready !== 1'b1) $display("FAIL fp_ready: got %0b exp 1", ext_ready); else passes++;
    tick();
    ext_valid = 1'b0;
    checks++; if (wb_dest !== 4'd11) $display("FAIL fp_pop1: got %0d exp 11", wb_dest); else passes++;
    checks++; if (pending_mask !== 16'h7800) $display("FAIL fp_mask: got %h exp 7800", pending_mask); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wb_en !== 1'b1 || wb_dest !== 4'(12 + i)) $display("FAIL fp_drain%0d: got en=%0b %0d exp 1 %0d", i, wb_en, wb_dest, 12 + i); else passes++;
    end
    checks++; if (wb_data !== 32'hEE) $display("FAIL fp_late_data: got %h exp ee", wb_data); else passes++;
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL fp_idle: got %0b exp 0", wb_en); else passes++;
  endtask

  task automatic test_pc_write;
    checks++; if (pc_write_err !== 1'b0) $display("FAIL pc_pre: got %0b exp 0", pc_write_err); else passes++;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'h1;
    ext_valid = 1'b1; ext_dest = 4'd2; ext_data = 32'h22;
    tick();
    ext_valid = 1'b0;
    alu_dest = 4'd15; alu_data = 32'hBAD;
    tick();
    alu_valid = 1'b0;
    checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd2 || wb_data !== 32'h22)
      $display("FAIL pc_alu_pop: got en=%0b %0d/%h exp 1 2/22", wb_en, wb_dest, wb_data);
    else passes++;
    checks++; if (pc_write_err !== 1'b1) $display("FAIL pc_err_set: got %0b exp 1", pc_write_err); else passes++;
    ext_valid = 1'b1; ext_dest = 4'd15; ext_data = 32'h55;
    checks++; if (ext_ready !== 1'b1) $display("FAIL pc_ext_ready: got %0b exp 1", ext_ready); else passes++;
    tick();
    ext_valid = 1'b0;
    checks++; if (wb_en !== 1'b0) $display("FAIL pc_ext_drop: got %0b exp 0", wb_en); else passes++;
    checks++; if (pending_mask !== 16'h0) $display("FAIL pc_ext_mask: got %h exp 0", pending_mask); else passes++;
    tick();
    checks++; if (wb_en !== 1'b0) $display("FAIL pc_ext_drop2: got %0b exp 0", wb_en); else passes++;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (pc_write_err !== 1'b1) $display("FAIL pc_err_sticky: got %0b exp 1", pc_write_err); else passes++;
  endtask

  task automatic test_reset_mid;
    alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      ext_valid = 1'b1; ext_dest = 4'(2 + i); ext_data = 32'(i);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (pending_mask !== 16'h0) $display("FAIL rmid_mask: got %h exp 0", pending_mask); else passes++;
    checks++; if (wb_en !== 1'b0) $display("FAIL rmid_en: got %0b exp 0", wb_en); else passes++;
    checks++; if (ext_ready !== 1'b0) $display("FAIL rmid_ready: got %0b exp 0", ext_ready); else passes++;
    checks++; if (pc_write_err !== 1'b0) $display("FAIL rmid_pc_err: got %0b exp 0", pc_write_err); else passes++;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (wb_en !== 1'b0 || pending_mask !== 16'h0)
        $display("FAIL rmid_after%0d: got en=%0b mask=%h exp 0 0000", i, wb_en, pending_mask);
      else passes++;
    end
    checks++; if (ext_ready !== 1'b1) $display("FAIL rmid_ready_back: got %0b exp 1", ext_ready); else passes++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ext_latency();
    test_fill_drain();
    test_starve();
    test_full_pop();
    test_pc_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
